// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory bank.
// Holds the clear-sweep state enum, default widths and depth helper.
package data_mem_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/data_mem_clear_fsm.sv
// Clear sequencer: walks every word once, one per cycle.
// Provides Busy/Ready decode and the sweep write address.
import data_mem_pkg::*;

module data_mem_clear_fsm #(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    output logic              ready,
    output logic              busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state;
    logic [ADDR_W-1:0] cnt;

    // State and sweep counter; counter wraps to 0 on the last entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clear) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign ready    = (state == IDLE);
    assign busy     = (state == CLEAR);
    assign clr_en   = busy;
    assign clr_addr = cnt;

endmodule

// File: rtl/data_memory_bank.sv
// DEPTH x DATA_W data memory with registered read and clear sweep.
// Macro DATA_MEM_WRITE_FIRST_EN adds a read-only port with write-first forwarding.
import data_mem_pkg::*;

module data_memory_bank #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              We,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              Clear,
`ifdef DATA_MEM_WRITE_FIRST_EN
    input  logic              Rd_req,
    input  logic [ADDR_W-1:0] Rd_address,
`endif
    output logic              Ready,
    output logic [DATA_W-1:0] Data_out,
    output logic              Rd_valid,
    output logic              Busy
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] rd_data;

    data_mem_clear_fsm #(
        .ADDR_W(ADDR_W)
    ) u_clear_fsm (
        .clk     (Clk),
        .rst_n   (Reset),
        .clear   (Clear),
        .ready   (Ready),
        .busy    (Busy),
        .clr_en  (clr_en),
        .clr_addr(clr_addr)
    );

    assign wr_acc = Ready & Req & We;

`ifdef DATA_MEM_WRITE_FIRST_EN
    // Port-A read wins; otherwise the side port reads, forwarding a same-edge write
    always_comb begin
        rd_acc  = 1'b0;
        rd_data = mem[Address];
        if (Ready && Req && !We) begin
            rd_acc  = 1'b1;
            rd_data = mem[Address];
        end else if (Ready && Rd_req) begin
            rd_acc  = 1'b1;
            if (wr_acc && (Rd_address == Address)) begin
                rd_data = Data_in;
            end else begin
                rd_data = mem[Rd_address];
            end
        end
    end
`else
    // Single port: a read never coincides with a write, so read-first is implicit
    always_comb begin
        rd_acc  = Ready & Req & ~We;
        rd_data = mem[Address];
    end
`endif

    // Array update: sweep zeroes one word, else accepted request writes
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc) begin
            mem[Address] <= Data_in;
        end
    end

    // Read register and one-cycle valid strobe
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Data_out <= '0;
            Rd_valid <= 1'b0;
        end else begin
            Rd_valid <= rd_acc;
            if (rd_acc) begin
                Data_out <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_bank.sv
// Self-checking bench for data_memory_bank.
// Reads push expected data to a queue; a monitor pops it on Rd_valid.
module tb_data_memory_bank;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Req = 1'b0;
    logic       We = 1'b0;
    logic [4:0] Address = '0;
    logic [7:0] Data_in = '0;
    logic       Clear = 1'b0;
    logic       Ready;
    logic [7:0] Data_out;
    logic       Rd_valid;
    logic       Busy;
`ifdef DATA_MEM_WRITE_FIRST_EN
    logic       Rd_req = 1'b0;
    logic [4:0] Rd_address = '0;
`endif

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        bit         we;
        logic [4:0] addr;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    data_memory_bank dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Req     (Req),
        .We      (We),
        .Address (Address),
        .Data_in (Data_in),
        .Clear   (Clear),
`ifdef DATA_MEM_WRITE_FIRST_EN
        .Rd_req    (Rd_req),
        .Rd_address(Rd_address),
`endif
        .Ready   (Ready),
        .Data_out(Data_out),
        .Rd_valid(Rd_valid),
        .Busy    (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest pending read
    always @(negedge Clk) begin
        if (Reset && Rd_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_rd_valid: got data %0h, expected no strobe",
                         Data_out);
            end else begin
                check("rd_data", {24'b0, Data_out}, {24'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Req = 1'b0;
        We = 1'b0;
        Clear = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        Req = 1'b1;
        We = 1'b1;
        Address = a;
        Data_in = d;
        step();
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] e);
        Req = 1'b1;
        We = 1'b0;
        Address = a;
        exp_q.push_back(e);
        step();
    endtask

    initial begin
        int busy_cnt;
        vecs[0] = '{1'b1, 5'd17, 8'h3C, 8'h00};
        vecs[1] = '{1'b0, 5'd17, 8'h00, 8'h3C};
        vecs[2] = '{1'b0, 5'd18, 8'h00, 8'h00};
        vecs[3] = '{1'b1, 5'd9,  8'h11, 8'h00};
        vecs[4] = '{1'b0, 5'd9,  8'h00, 8'h11};
        vecs[5] = '{1'b1, 5'd9,  8'h5A, 8'h00};
        vecs[6] = '{1'b0, 5'd9,  8'h00, 8'h5A};
        vecs[7] = '{1'b1, 5'd31, 8'h80, 8'h00};
        vecs[8] = '{1'b0, 5'd31, 8'h00, 8'h80};
        vecs[9] = '{1'b0, 5'd0,  8'h00, 8'h00};

        // Reset state
        #12;
        check("rst_data_out", {24'b0, Data_out}, 32'h0);
        check("rst_rd_valid", {31'b0, Rd_valid}, 32'h0);
        check("rst_busy", {31'b0, Busy}, 32'h0);
        check("rst_ready", {31'b0, Ready}, 32'h1);
        @(negedge Clk);
        Reset = 1'b1;
        step();

        // Preload then async reset wipes array and read register
        wr(5'd3, 8'hA5);
        rd(5'd3, 8'hA5);
        idle();
        step();
        step();
        #1;
        Reset = 1'b0;
        #1;
        check("async_rst_data_out", {24'b0, Data_out}, 32'h0);
        check("async_rst_rd_valid", {31'b0, Rd_valid}, 32'h0);
        #3;
        Reset = 1'b1;
        step();
        rd(5'd3, 8'h00);
        idle();
        step();

        // Table vectors
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].din);
            else rd(vecs[i].addr, vecs[i].exp);
        end
        idle();
        step();

`ifdef DATA_MEM_WRITE_FIRST_EN
        // Same-edge write and side read of addr 9 forward the new data
        wr(5'd9, 8'h11);
        idle();
        step();
        Req = 1'b1;
        We = 1'b1;
        Address = 5'd9;
        Data_in = 8'h5A;
        Rd_req = 1'b1;
        Rd_address = 5'd9;
        exp_q.push_back(8'h5A);
        step();
        Rd_req = 1'b0;
        idle();
        step();
`endif

        // Back-to-back fill and readback
        for (int a = 0; a < 32; a++) begin
            check("ready_wr", {31'b0, Ready}, 32'h1);
            wr(a[4:0], a[7:0] ^ 8'hFF);
        end
        for (int a = 0; a < 32; a++) begin
            check("ready_rd", {31'b0, Ready}, 32'h1);
            rd(a[4:0], a[7:0] ^ 8'hFF);
        end
        idle();
        step();
        step();
        check("readback_drained", exp_q.size(), 32'h0);

        // Clear together with a write; requests and Clear ignored while busy
        Clear = 1'b1;
        wr(5'd5, 8'h77);
        busy_cnt = 0;
        while (Busy && busy_cnt < 100) begin
            busy_cnt++;
            if (Ready) begin
                tests++;
                fails++;
                $display("FAIL ready_in_busy: got 1, expected 0");
            end
            Clear = 1'b1;
            Req = 1'b1;
            We = busy_cnt[0];
            Address = 5'd7;
            Data_in = 8'hEE;
            step();
        end
        idle();
        check("busy_cycles", busy_cnt, 32);
        check("ready_after_clear", {31'b0, Ready}, 32'h1);
        rd(5'd5, 8'h00);
        rd(5'd7, 8'h00);
        rd(5'd0, 8'h00);
        rd(5'd31, 8'h00);
        idle();
        step();

        // Reset at sweep cycle 10 abandons the sweep and zeroes everything
        wr(5'd20, 8'h42);
        wr(5'd25, 8'h99);
        idle();
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        for (int c = 0; c < 10; c++) step();
        check("busy_mid_sweep", {31'b0, Busy}, 32'h1);
        #1;
        Reset = 1'b0;
        #1;
        check("busy_on_reset", {31'b0, Busy}, 32'h0);
        check("ready_on_reset", {31'b0, Ready}, 32'h1);
        #3;
        Reset = 1'b1;
        step();
        check("ready_after_reset", {31'b0, Ready}, 32'h1);
        rd(5'd20, 8'h00);
        rd(5'd25, 8'h00);
        rd(5'd3, 8'h00);
        idle();
        step();
        step();
        check("final_drained", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
